// File: rtl/requant_pkg.sv
`default_nettype none
// =============================================================================
// requant_pkg : shared types, constants and rounding helper for requant_pipe
// Revision    : 1.0
// =============================================================================
package requant_pkg;

    localparam int LANE_ACC_W = 32;

    typedef logic signed [LANE_ACC_W-1:0] acc_t;
    typedef logic signed [LANE_ACC_W-1:0] mult_t;
    typedef logic signed [5:0]            shift_t;

    localparam logic signed [63:0] NUDGE_POS  = 64'sd1073741824;
    localparam logic signed [63:0] NUDGE_NEG  = -64'sd1073741823;
    localparam logic signed [63:0] TRUNC_BIAS = 64'sd2147483647;
    localparam acc_t               INT32_MAX  = 32'sh7FFF_FFFF;
    localparam acc_t               INT32_MIN  = 32'sh8000_0000;

    // Rounding divide by 2^rsh, ties away from zero.
    function automatic acc_t rdbpot(input acc_t h, input logic [4:0] rsh);
        logic [31:0] mask;
        logic [31:0] rem;
        logic [31:0] thr;
        acc_t        r;
        mask = (32'd1 << rsh) - 32'd1;
        rem  = h & mask;
        thr  = (mask >> 1) + {31'd0, h[31]};
        r    = h >>> rsh;
        if (rem > thr) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/requant_lane.sv
`default_nettype none
// =============================================================================
// requant_lane : one lane of the four-stage requantiser datapath
// Revision     : 1.0
// =============================================================================
module requant_lane
    import requant_pkg::*;
#(
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  acc_t                      acc,
    input  mult_t                     mult,
    input  logic signed [SHIFT_W-1:0] shift,
    input  logic signed [31:0]        out_offset,
    input  logic signed [OUT_W-1:0]   act_min,
    input  logic signed [OUT_W-1:0]   act_max,
    output logic signed [OUT_W-1:0]   res
);

    acc_t               r_x;
    mult_t              r_mult;
    logic [4:0]         r_rsh1;
    logic signed [63:0] r_p;
    logic               r_sat;
    logic [4:0]         r_rsh2;
    acc_t               r_h;
    logic [4:0]         r_rsh3;

    logic [4:0]         w_lsh;
    logic [4:0]         w_rsh;
    logic signed [63:0] w_prod;
    logic signed [63:0] w_sum;
    logic signed [63:0] w_quo;
    acc_t               w_h;
    acc_t               w_r;
    logic signed [32:0] w_o;
    logic signed [32:0] w_lo;
    logic signed [32:0] w_hi;
    logic signed [OUT_W-1:0] w_res;

    always_comb begin
        w_lsh  = shift[SHIFT_W-1] ? 5'd0 : 5'(shift);
        w_rsh  = shift[SHIFT_W-1] ? 5'(-shift) : 5'd0;
        w_prod = $signed({{32{r_x[31]}}, r_x}) * $signed({{32{r_mult[31]}}, r_mult});

        // Division truncates toward zero, so negative sums get a bias before the shift.
        w_sum  = r_p + (r_p[63] ? NUDGE_NEG : NUDGE_POS);
        w_quo  = w_sum[63] ? ((w_sum + TRUNC_BIAS) >>> 31) : (w_sum >>> 31);
        w_h    = r_sat ? INT32_MAX : acc_t'(w_quo);

        w_r    = rdbpot(r_h, r_rsh3);
        w_o    = $signed({w_r[31], w_r}) + $signed({out_offset[31], out_offset});
        w_lo   = $signed({{(33-OUT_W){act_min[OUT_W-1]}}, act_min});
        w_hi   = $signed({{(33-OUT_W){act_max[OUT_W-1]}}, act_max});
        if (w_o < w_lo) begin
            w_res = act_min;
        end else if (w_o > w_hi) begin
            w_res = act_max;
        end else begin
            w_res = w_o[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_mult <= '0;
            r_rsh1 <= '0;
            r_p    <= '0;
            r_sat  <= 1'b0;
            r_rsh2 <= '0;
            r_h    <= '0;
            r_rsh3 <= '0;
            res    <= '0;
        end else if (en) begin
            r_x    <= acc <<< w_lsh;
            r_mult <= mult;
            r_rsh1 <= w_rsh;
            r_p    <= w_prod;
            r_sat  <= (r_x == INT32_MIN) && (r_mult == INT32_MIN);
            r_rsh2 <= r_rsh1;
            r_h    <= w_h;
            r_rsh3 <= r_rsh2;
            res    <= w_res;
        end
    end

endmodule
`default_nettype wire

// File: rtl/requant_pipe.sv
`default_nettype none
// =============================================================================
// requant_pipe : multi-lane TFLite-exact requantiser, 4-stage stall-as-a-whole
// Revision     : 1.0
// =============================================================================
module requant_pipe
    import requant_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*32-1:0]        in_acc,
    input  logic [LANES*32-1:0]        in_mult,
    input  logic [LANES*SHIFT_W-1:0]   in_shift,
    input  logic signed [31:0]         out_offset,
    input  logic signed [OUT_W-1:0]    act_min,
    input  logic signed [OUT_W-1:0]    act_max,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*OUT_W-1:0]     out_data,
    output logic                       busy
);

    localparam int SHIFT_MIN = -31;
    localparam int SHIFT_MAX = 31;

    logic [3:0] r_vld;
    logic       w_en;

    assign w_en      = !r_vld[3] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_vld[3];
    assign busy      = |r_vld;

    // Bubbles travel with the data; nothing collapses them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 4'b0000;
        end else if (w_en) begin
            r_vld <= {r_vld[2:0], in_valid};
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            requant_lane #(
                .OUT_W   (OUT_W),
                .SHIFT_W (SHIFT_W)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (w_en),
                .acc        (in_acc[32*i +: 32]),
                .mult       (in_mult[32*i +: 32]),
                .shift      (in_shift[SHIFT_W*i +: SHIFT_W]),
                .out_offset (out_offset),
                .act_min    (act_min),
                .act_max    (act_max),
                .res        (out_data[OUT_W*i +: OUT_W])
            );

`ifndef SYNTHESIS
            a_shift_range : assert property (@(posedge clk) disable iff (!rst_n)
                (in_valid && in_ready) |->
                    ((int'($signed(in_shift[SHIFT_W*i +: SHIFT_W])) >= SHIFT_MIN) &&
                     (int'($signed(in_shift[SHIFT_W*i +: SHIFT_W])) <= SHIFT_MAX)));
`endif
        end
    endgenerate

endmodule
`default_nettype wire
